// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex glyph table, blank pattern,
// segment bit positions, filter state type and the glyph decode helper.
package seg7_pkg;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_HEX [16] = '{
        SEG_HEX_0, SEG_HEX_1, SEG_HEX_2, SEG_HEX_3,
        SEG_HEX_4, SEG_HEX_5, SEG_HEX_6, SEG_HEX_7,
        SEG_HEX_8, SEG_HEX_9, SEG_HEX_A, SEG_HEX_B,
        SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
    };

    typedef enum logic {
        ST_UNSTABLE = 1'b0,
        ST_STABLE   = 1'b1
    } filt_state_e;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
    } seg7_dec_t;

    // Blank and unknown glyphs both decode to digit 0; only unknown sets err.
    function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
        seg7_dec_t d;
        d.digit = 4'd0;
        d.blank = (pat == SEG_BLANK);
        d.err   = (pat != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_HEX[i]) begin
                d.digit = 4'(i);
                d.err   = 1'b0;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Two-flop synchronizer plus stability filter: emits a one-cycle pulse with the
// candidate value once it has been sampled STABLE_CYCLES times in a row.
module seg7_sync_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_seg,
    output logic        o_stable_pulse,
    output logic [7:0]  o_stable_value,
    output filt_state_e o_state
);

    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_cand;
    logic [7:0]  r_count;
    logic        r_pulse;
    filt_state_e r_state;

    logic [7:0]  w_cand_nxt;
    logic [7:0]  w_count_nxt;
    logic        w_pulse_nxt;
    filt_state_e w_state_nxt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
            r_cand  <= 8'hFF;
            r_count <= 8'd0;
            r_pulse <= 1'b0;
            r_state <= ST_UNSTABLE;
        end else begin
            r_sync1 <= i_seg;
            r_sync2 <= r_sync1;
            r_cand  <= w_cand_nxt;
            r_count <= w_count_nxt;
            r_pulse <= w_pulse_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_count_nxt = r_count;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_UNSTABLE: begin
                if (r_sync2 != r_cand) begin
                    w_cand_nxt  = r_sync2;
                    w_count_nxt = 8'd1;
                end else begin
                    w_count_nxt = r_count + 8'd1;
                    if (r_count + 8'd1 == 8'(STABLE_CYCLES)) begin
                        w_state_nxt = ST_STABLE;
                        w_pulse_nxt = 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                if (r_sync2 != r_cand) begin
                    w_state_nxt = ST_UNSTABLE;
                    w_cand_nxt  = r_sync2;
                    w_count_nxt = 8'd1;
                end
            end
            default: w_state_nxt = ST_UNSTABLE;
        endcase
    end

    // r_cand is unchanged on the cycle after the transition, so it is the stable value.
    assign o_stable_pulse = r_pulse;
    assign o_stable_value = r_cand;
    assign o_state        = r_state;

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Observes an asynchronous active-low 7-segment bus and reports each newly
// stable pattern as a decoded event over a valid/ready output with overrun count.
module seg7_pattern_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        blank,
    output logic        err,
    output logic [7:0]  overrun_cnt,
    output filt_state_e dbg_state
);

    // Handshake: an event transfers on any rising edge where out_valid && out_ready;
    // fields hold steady while out_valid is high unless a newer event overwrites them.

    logic       w_pulse;
    logic [7:0] w_value;
    logic       w_new_event;
    seg7_dec_t  w_dec;

    logic [7:0] r_last;
    logic       r_reported;

    seg7_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_seg          (seg),
        .o_stable_pulse (w_pulse),
        .o_stable_value (w_value),
        .o_state        (dbg_state)
    );

    assign w_dec       = seg7_decode(w_value[SEG_G_BIT:SEG_A_BIT]);
    assign w_new_event = w_pulse && (!r_reported || (w_value != r_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= 8'hFF;
            r_reported  <= 1'b0;
            out_valid   <= 1'b0;
            digit       <= 4'd0;
            dp          <= 1'b0;
            blank       <= 1'b0;
            err         <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (w_new_event) begin
            r_last     <= w_value;
            r_reported <= 1'b1;
            out_valid  <= 1'b1;
            digit      <= w_dec.digit;
            dp         <= ~w_value[SEG_DP_BIT];
            blank      <= w_dec.blank;
            err        <= w_dec.err;
            // A same-edge transfer consumes the old event, so only an unaccepted one is lost.
            if (out_valid && !out_ready && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
